// File: rtl/dmx_frame_ctrl.sv
// rtl/dmx_frame_ctrl.sv - DMX512 receive frame sequencer: break framing, start-code
// qualification, slot RAM writes, completion/error reporting and loss-of-signal timeout.
module dmx_frame_ctrl #(
   parameter logic [7:0]  START_CODE   = 8'h00,
   parameter int unsigned MAX_SLOTS    = 512,
   parameter int unsigned TIMEOUT_CLKS = 16000000
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   input  logic       i_Rx_Break,
   output logic       o_Wr_En,
   output logic [8:0] o_Wr_Addr,
   output logic [7:0] o_Wr_Data,
   output logic       o_Frame_Done,
   output logic [9:0] o_Slot_Count,
   output logic [7:0] o_Start_Code,
   output logic       o_Frame_Err,
   output logic       o_Signal_Lost
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SC  = 2'd1,
      RX_SLOTS = 2'd2,
      SKIP     = 2'd3
   } state_t;

   localparam logic [9:0]  MAX_CNT  = 10'(MAX_SLOTS);
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CLKS - 1);

   state_t      state_q;
   logic [9:0]  slot_cnt_q;
   logic [9:0]  slot_cnt_d;
   logic [23:0] tmo_q;
   logic [23:0] tmo_d;
   logic        activity;
   logic        tmo_hit;

   assign activity   = i_Rx_DV | i_Rx_Break;
   assign slot_cnt_d = slot_cnt_q + 10'd1;

   // Idle-time counter saturates at its terminal value so the lost condition persists.
   always_comb begin
      tmo_d = tmo_q;
      if (activity) begin
         tmo_d = '0;
      end else if (tmo_q != TMO_LAST) begin
         tmo_d = tmo_q + 24'd1;
      end
   end

   assign tmo_hit = !activity && (tmo_d == TMO_LAST);

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q       <= IDLE;
         slot_cnt_q    <= '0;
         tmo_q         <= '0;
         o_Wr_En       <= 1'b0;
         o_Wr_Addr     <= '0;
         o_Wr_Data     <= '0;
         o_Frame_Done  <= 1'b0;
         o_Slot_Count  <= '0;
         o_Start_Code  <= '0;
         o_Frame_Err   <= 1'b0;
         o_Signal_Lost <= 1'b0;
      end else begin
         o_Wr_En      <= 1'b0;
         o_Frame_Done <= 1'b0;
         o_Frame_Err  <= 1'b0;
         tmo_q        <= tmo_d;

         if (tmo_hit) begin
            // Partial frame is abandoned silently; only a break can resynchronise.
            state_q       <= IDLE;
            slot_cnt_q    <= '0;
            o_Signal_Lost <= 1'b1;
         end else begin
            if (i_Rx_Break) begin
               o_Signal_Lost <= 1'b0;
            end

            unique case (state_q)
               IDLE: begin
                  if (i_Rx_Break) begin
                     state_q <= WAIT_SC;
                  end
               end

               WAIT_SC: begin
                  if (i_Rx_Break) begin
                     o_Frame_Err <= 1'b1;
                  end else if (i_Rx_DV) begin
                     o_Start_Code <= i_Rx_Byte;
                     slot_cnt_q   <= '0;
                     state_q      <= (i_Rx_Byte == START_CODE) ? RX_SLOTS : SKIP;
                  end
               end

               RX_SLOTS: begin
                  if (i_Rx_Break) begin
                     o_Frame_Done <= 1'b1;
                     o_Slot_Count <= slot_cnt_q;
                     slot_cnt_q   <= '0;
                     state_q      <= WAIT_SC;
                  end else if (i_Rx_DV) begin
                     o_Wr_En    <= 1'b1;
                     o_Wr_Addr  <= slot_cnt_q[8:0];
                     o_Wr_Data  <= i_Rx_Byte;
                     slot_cnt_q <= slot_cnt_d;
                     if (slot_cnt_d == MAX_CNT) begin
                        o_Frame_Done <= 1'b1;
                        o_Slot_Count <= MAX_CNT;
                        state_q      <= SKIP;
                     end
                  end
               end

               SKIP: begin
                  if (i_Rx_Break) begin
                     state_q <= WAIT_SC;
                  end
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmx_frame_ctrl.sv
// tb/tb_dmx_frame_ctrl.sv - self-checking bench for dmx_frame_ctrl.
module tb_dmx_frame_ctrl;

   localparam int TMO = 50;

   typedef struct packed {
      logic       we;
      logic [8:0] addr;
      logic [7:0] data;
      logic       fd;
      logic [9:0] cnt;
      logic [7:0] sc;
      logic       fe;
      logic       lost;
   } outs_t;

   typedef struct {
      logic       dv;
      logic       brk;
      logic [7:0] b;
      outs_t      exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       brk = 1'b0;
   logic       wr_en;
   logic [8:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_done;
   logic [9:0] slot_count;
   logic [7:0] start_code;
   logic       frame_err;
   logic       signal_lost;

   int    errors = 0;
   int    checks = 0;
   vec_t  vt[$];
   outs_t e;

   always #5 clk = ~clk;

   dmx_frame_ctrl #(
      .START_CODE  (8'h00),
      .MAX_SLOTS   (512),
      .TIMEOUT_CLKS(TMO)
   ) dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_Rx_DV      (dv),
      .i_Rx_Byte    (rx_byte),
      .i_Rx_Break   (brk),
      .o_Wr_En      (wr_en),
      .o_Wr_Addr    (wr_addr),
      .o_Wr_Data    (wr_data),
      .o_Frame_Done (frame_done),
      .o_Slot_Count (slot_count),
      .o_Start_Code (start_code),
      .o_Frame_Err  (frame_err),
      .o_Signal_Lost(signal_lost)
   );

   function automatic string fmt(outs_t o);
      return $sformatf("we=%b addr=%0d data=%h fd=%b cnt=%0d sc=%h fe=%b lost=%b",
                       o.we, o.addr, o.data, o.fd, o.cnt, o.sc, o.fe, o.lost);
   endfunction

   task automatic check(input string name, input outs_t exp);
      outs_t act;
      act = '{we: wr_en, addr: wr_addr, data: wr_data, fd: frame_done, cnt: slot_count,
              sc: start_code, fe: frame_err, lost: signal_lost};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %s required %s", name, fmt(act), fmt(exp));
      end
   endtask

   task automatic step(input logic d, input logic k, input logic [7:0] b);
      @(negedge clk);
      dv      = d;
      brk     = k;
      rx_byte = b;
      @(posedge clk);
      #1;
   endtask

   function automatic void v(input logic d, input logic k, input logic [7:0] b,
                             input logic we, input int addr, input logic [7:0] data,
                             input logic fd, input int cnt, input logic [7:0] sc,
                             input logic fe);
      vec_t t;
      t.dv  = d;
      t.brk = k;
      t.b   = b;
      t.exp = '{we: we, addr: 9'(addr), data: data, fd: fd, cnt: 10'(cnt),
                sc: sc, fe: fe, lost: 1'b0};
      vt.push_back(t);
   endfunction

   initial begin
      // dv brk byte | we addr data fd cnt sc fe
      v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);   // IDLE ignores DV
      v(1, 0, 8'h44, 0, 0, 8'h00, 0, 0, 8'h00, 0);
      v(0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
      v(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
      v(1, 0, 8'h11, 1, 0, 8'h11, 0, 0, 8'h00, 0);
      v(1, 0, 8'h22, 1, 1, 8'h22, 0, 0, 8'h00, 0);
      v(1, 0, 8'h33, 1, 2, 8'h33, 0, 0, 8'h00, 0);
      v(0, 1, 8'h00, 0, 2, 8'h33, 1, 3, 8'h00, 0);
      v(0, 0, 8'h00, 0, 2, 8'h33, 0, 3, 8'h00, 0);
      v(0, 1, 8'h00, 0, 2, 8'h33, 0, 3, 8'h00, 1);   // break in WAIT_SC: empty frame
      v(1, 0, 8'hCC, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h01, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h02, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h03, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h04, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h05, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(0, 1, 8'h00, 0, 2, 8'h33, 0, 3, 8'hCC, 0);
      v(1, 0, 8'h00, 0, 2, 8'h33, 0, 3, 8'h00, 0);
      v(1, 0, 8'hAA, 1, 0, 8'hAA, 0, 3, 8'h00, 0);
      v(1, 0, 8'hBB, 1, 1, 8'hBB, 0, 3, 8'h00, 0);
      v(0, 1, 8'h00, 0, 1, 8'hBB, 1, 2, 8'h00, 0);
      v(0, 1, 8'h00, 0, 1, 8'hBB, 0, 2, 8'h00, 1);
      v(1, 0, 8'h00, 0, 1, 8'hBB, 0, 2, 8'h00, 0);
      v(1, 0, 8'h5A, 1, 0, 8'h5A, 0, 2, 8'h00, 0);
      v(0, 1, 8'h00, 0, 0, 8'h5A, 1, 1, 8'h00, 0);
      v(1, 0, 8'h00, 0, 0, 8'h5A, 0, 1, 8'h00, 0);
      v(1, 0, 8'h77, 1, 0, 8'h77, 0, 1, 8'h00, 0);
      v(1, 1, 8'h99, 0, 0, 8'h77, 1, 1, 8'h00, 0);   // break beats simultaneous DV

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].dv, vt[i].brk, vt[i].b);
         check($sformatf("vec%0d", i), vt[i].exp);
      end

      // full frame: 514 bytes, only 512 written
      e = vt[vt.size() - 1].exp;
      e.fd = 1'b0;
      step(1, 0, 8'h00);
      check("max_sc", e);
      for (int i = 0; i < 514; i++) begin
         logic [7:0] b;
         b = 8'(i + 3);
         step(1, 0, b);
         e.we = (i < 512);
         e.fd = (i == 511);
         if (i < 512) begin
            e.addr = 9'(i);
            e.data = b;
         end
         if (i == 511) e.cnt = 10'd512;
         check($sformatf("max_byte%0d", i), e);
      end
      step(0, 1, 8'h00);
      e.we = 1'b0;
      e.fd = 1'b0;
      check("max_break_no_done", e);

      // timeout mid-frame
      step(1, 0, 8'h00);
      check("tmo_sc", e);
      step(1, 0, 8'h01);
      e.we = 1'b1; e.addr = 9'd0; e.data = 8'h01;
      check("tmo_b0", e);
      step(1, 0, 8'h02);
      e.addr = 9'd1; e.data = 8'h02;
      check("tmo_b1", e);
      e.we = 1'b0;
      for (int k = 1; k <= TMO + 2; k++) begin
         step(0, 0, 8'h00);
         e.lost = (k >= TMO - 1);
         check($sformatf("tmo_idle%0d", k), e);
      end
      step(1, 0, 8'h00);
      check("lost_dv_keeps", e);
      step(1, 0, 8'h55);
      check("lost_idle_no_wr", e);
      step(0, 1, 8'h00);
      e.lost = 1'b0;
      check("lost_break_clears", e);
      step(1, 0, 8'h00);
      check("post_lost_sc", e);
      step(1, 0, 8'h66);
      e.we = 1'b1; e.addr = 9'd0; e.data = 8'h66;
      check("post_lost_wr", e);
      step(0, 1, 8'h00);
      e.we = 1'b0; e.fd = 1'b1; e.cnt = 10'd1;
      check("post_lost_done", e);

      // reset mid-frame after 3 slots
      step(1, 0, 8'h00);
      e.fd = 1'b0;
      check("rst_sc", e);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 8'hC1 + 8'(i));
         e.we = 1'b1; e.addr = 9'(i); e.data = 8'hC1 + 8'(i);
         check($sformatf("rst_pre%0d", i), e);
      end
      @(negedge clk);
      dv = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_async", '0);
      @(posedge clk);
      #1;
      check("rst_held", '0);
      @(negedge clk);
      rst_n = 1'b1;
      e = '0;
      step(0, 1, 8'h00);
      check("rst_brk", e);
      step(1, 0, 8'h00);
      check("rst_f_sc", e);
      step(1, 0, 8'hA1);
      e.we = 1'b1; e.addr = 9'd0; e.data = 8'hA1;
      check("rst_f_w0", e);
      step(1, 0, 8'hA2);
      e.addr = 9'd1; e.data = 8'hA2;
      check("rst_f_w1", e);
      step(0, 1, 8'h00);
      e.we = 1'b0; e.fd = 1'b1; e.cnt = 10'd2;
      check("rst_f_done", e);
      step(0, 0, 8'h00);
      e.fd = 1'b0;
      check("rst_f_hold", e);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
